// File: rtl/muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_hilo_unit
//  Purpose  : Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO
//             registers. One product/quotient bit per clock, result committed
//             to HI/LO in a final fix-up cycle. Also services MTHI/MTLO.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched operation context
    logic              r_is_div;
    logic              r_neg_res;   // quotient / product must be negated
    logic              r_neg_rem;   // remainder takes the dividend's sign
    logic              r_dz;
    logic [CW-1:0]     r_cnt;

    // Shared iteration datapath:
    //   multiply: r_acc_hi = running upper half, r_acc_lo = multiplier
    //             shifting out as product bits shift in, r_opnd = multiplicand
    //   divide  : r_acc_hi = partial remainder, r_acc_lo = dividend shifting
    //             out as quotient bits shift in, r_opnd = divisor
    logic [WIDTH-1:0]  r_acc_hi;
    logic [WIDTH-1:0]  r_acc_lo;
    logic [WIDTH-1:0]  r_opnd;

    logic              r_busy;
    logic              r_done;
    logic              r_dz_out;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;

    // Combinational helpers
    logic              w_signed;
    logic              w_b_zero;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic              w_last;
    logic [WIDTH:0]    w_mul_sum;
    logic [WIDTH:0]    w_shift;
    logic [WIDTH-1:0]  w_diff;
    logic              w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]  w_quo_fix;
    logic [WIDTH-1:0]  w_rem_fix;

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

    // Operand conditioning and per-iteration arithmetic
    always_comb begin
        w_signed   = ~op[0];
        w_b_zero   = (b == '0);
        w_a_mag    = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        w_b_mag    = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
        w_last     = (r_cnt == CW'(WIDTH - 1));

        // add multiplicand to the upper half when the current multiplier bit is set
        w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

        // restoring divide: shift next dividend bit into the remainder and trial-subtract
        w_shift    = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_opnd});
        w_diff     = w_shift[WIDTH-1:0] - r_opnd;

        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = r_neg_res ? (~w_prod + 1'b1) : w_prod;
        w_quo_fix  = r_neg_res ? (~r_acc_lo + 1'b1) : r_acc_lo;
        w_rem_fix  = r_neg_rem ? (~r_acc_hi + 1'b1) : r_acc_hi;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (op[1] && w_b_zero) begin
                        w_next = S_FIX;
                    end else if (op[1]) begin
                        w_next = S_DIV;
                    end else begin
                        w_next = S_MUL;
                    end
                end
            end
            S_MUL:   if (w_last) w_next = S_FIX;
            S_DIV:   if (w_last) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dz_out  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (r_state == S_FIX);
            r_dz_out <= (r_state == S_FIX) && r_dz;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div  <= op[1];
                        r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_signed & a[WIDTH-1];
                        r_dz      <= op[1] & w_b_zero;
                        r_cnt     <= '0;
                        r_acc_hi  <= '0;
                        r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                        r_acc_lo  <= op[1] ? w_a_mag : w_b_mag;
                    end else begin
                        // register moves only when no operation is being launched
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_MUL: begin
                    r_acc_hi <= w_mul_sum[WIDTH:1];
                    r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_DIV: begin
                    r_acc_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                    r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    // a zero divisor leaves HI/LO untouched
                    if (!r_dz) begin
                        if (r_is_div) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_hilo_unit
//  Purpose  : Self-checking bench for muldiv_hilo_unit: directed scenarios
//             plus randomized operations against an arithmetic reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_hilo_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Architectural result {HI,LO} computed with plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0:    return 64'(sx * sy);
            2'd1:    return ux * uy;
            2'd2:    begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
            default: return {x % y, x / y};
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; reports the number of edges counted from here
    task automatic wait_done(input string tag, input int exp_lat);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
    endtask

    // Checks the commit against the model, then that done is a single pulse
    task automatic verify(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        logic [63:0] r;
        logic        dz;
        dz = o[1] && (y == 0);
        if (!dz) begin
            r = ref_result(o, x, y);
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_dz"}, 64'(div_by_zero), 64'(dz));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'({done, busy, div_by_zero}), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        launch(o, x, y);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        wait_done(tag, (o[1] && y == 0) ? 1 : 33);
        verify(tag, o, x, y);
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        mthi = wh; mtlo = wl; wdata = d;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'({busy, done, div_by_zero}), 64'(0));
        check("reset_hilo", {hi, lo}, 64'(0));
        reset = 1'b0;

        // Multiply cases
        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000);

        // Divide cases, including the signed overflow corner
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 2'd3, 32'd100, 32'd7);
        run_op("div_corner", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);

        // Preload then divide by zero: HI/LO kept
        mt_write(1'b1, 1'b0, 32'h1234);
        mt_write(1'b0, 1'b1, 32'h5678);
        run_op("divu_zero", 2'd3, 32'd55, 32'd0);
        run_op("div_zero", 2'd2, 32'hFFFF_0000, 32'd0);
        mt_write(1'b1, 1'b1, 32'hCAFE_F00D);

        // Start and mthi together in IDLE: write dropped, op proceeds
        @(negedge clk);
        op = 2'd1; a = 32'd6; b = 32'd7; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_done("start_wins", 33);
        verify("start_wins", 2'd1, 32'd6, 32'd7);

        // Start and mthi while busy are ignored
        launch(2'd1, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        op = 2'd3; a = 32'd9; b = 32'd3; start = 1'b1; mthi = 1'b1; wdata = 32'hBEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        wait_done("busy_ignore", 23);
        verify("busy_ignore", 2'd1, 32'd3, 32'd5);

        // Asynchronous reset mid-operation aborts and clears
        launch(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_status", 64'({busy, done, div_by_zero}), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", 2'd1, 32'd2, 32'd2);

        // Randomized operations with interleaved register moves
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = $urandom_range(1, 15);
                2: rx = 32'h8000_0000;
                3: ry = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op("rand", ro, rx, ry);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
